// File: rtl/lake_affine_stream_mem.sv
// Affine-scheduled stream memory: one write port and one read port, each
// driven by a DIMS-deep odometer that steps its schedule time and address.
module lake_affine_stream_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned DIMS       = 3,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned PORT_CFG_W = 1 + CNT_WIDTH * (3 * DIMS + 2),
  localparam int unsigned CFG_W      = 2 * PORT_CFG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [CFG_W-1:0]      config_memory,
  input  logic [DATA_WIDTH-1:0] port_0,
  output logic [DATA_WIDTH-1:0] port_1,
  output logic                  port_1_valid,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DSW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int unsigned CW  = CNT_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]          fire;
  logic [1:0]          port_done;
  logic [1:0][AW-1:0]  port_addr;

  // Port 0 is the write port, port 1 the read port; same schedule engine.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [PORT_CFG_W-1:0]     cfg;
    logic                      en;
    logic [DIMS-1:0][CW-1:0]   ext;
    logic [DIMS-1:0][CW-1:0]   sdel;
    logic [DIMS-1:0][CW-1:0]   adel;
    logic [CW-1:0]             soff;
    logic [CW-1:0]             aoff;
    logic [DIMS-1:0][CW-1:0]   iter;
    logic [CW-1:0]             sched;
    logic [CW-1:0]             addr;
    logic                      dflag;
    logic                      fire_c;
    logic                      found_c;
    logic [DSW-1:0]            dsel_c;

    assign cfg = config_memory[p*PORT_CFG_W +: PORT_CFG_W];
    assign en  = cfg[0];

    // Unpack the per-port configuration fields.
    always_comb begin
      soff = cfg[1 + CW*DIMS +: CW];
      aoff = cfg[1 + CW*(2*DIMS + 1) +: CW];
      for (int d = 0; d < int'(DIMS); d++) begin
        ext[d]  = cfg[1 + CW*d +: CW];
        sdel[d] = cfg[1 + CW*(DIMS + 1 + d) +: CW];
        adel[d] = cfg[1 + CW*(2*DIMS + 2 + d) +: CW];
      end
    end

    // Lowest dimension that can still advance; none means last iteration.
    always_comb begin
      found_c = 1'b0;
      dsel_c  = '0;
      for (int d = 0; d < int'(DIMS); d++) begin
        if (!found_c && (iter[d] < ext[d])) begin
          found_c = 1'b1;
          dsel_c  = DSW'(d);
        end
      end
    end

    assign fire_c = en & ~dflag & ~flush & (cycle_count == sched);

    // Odometer, schedule time and address state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        iter  <= '0;
        sched <= '0;
        addr  <= '0;
        dflag <= 1'b0;
      end else if (flush) begin
        iter  <= '0;
        sched <= soff;
        addr  <= aoff;
        dflag <= 1'b0;
      end else if (fire_c) begin
        if (found_c) begin
          for (int k = 0; k < int'(DIMS); k++) begin
            if (k < int'(dsel_c)) begin
              iter[k] <= '0;
            end else if (k == int'(dsel_c)) begin
              iter[k] <= iter[k] + CW'(1);
            end
          end
          sched <= sched + sdel[dsel_c];
          addr  <= addr + adel[dsel_c];
        end else begin
          dflag <= 1'b1;
        end
      end
    end

    assign fire[p]      = fire_c;
    assign port_done[p] = dflag | ~en;
    assign port_addr[p] = addr[AW-1:0];
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (fire[0]) begin
      mem[port_addr[0]] <= port_0;
    end
  end

  // Read data register: old contents win on a same-cycle collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_1       <= '0;
      port_1_valid <= 1'b0;
    end else begin
      port_1_valid <= fire[1];
      if (fire[1]) begin
        port_1 <= mem[port_addr[1]];
      end
    end
  end

  // Free-running schedule clock and aggregated completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      done        <= 1'b0;
    end else if (flush) begin
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      cycle_count <= cycle_count + CW'(1);
      done        <= &port_done;
    end
  end

endmodule
